// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one memory system between three requesters: single-cycle debug-SPI
//   writes, cpu16 data reads/writes and cpu16 instruction reads. Each cycle at
//   most one access is granted. The granted address is decoded on addr[15:12]
//   and the access is steered to the SRAM, the VRAM write port, the control
//   register (cpu_reset) or dropped as unmapped. Reads complete one cycle after
//   their grant, whatever the region, with a single-cycle rdy pulse.
//
// Ports:
//   clk, reset                  system clock, asynchronous active-high reset
//   dbg_we/dbg_waddr/dbg_wdata  debug write strobe; always wins its cycle
//   ins_rd_*                    instruction read request/address, rdy + data
//   dat_rw_addr, dat_wr_data    cpu data address and write data
//   dat_rd_req/dat_wr_req       cpu data read/write requests, held until rdy
//   dat_rd_rdy/dat_wr_rdy       data read/write completion pulses
//   dat_rd_data                 data read result, held between rdy pulses
//   sram_*                      SRAM read port (1-cycle latency) + write port
//   vram_*                      VRAM write port (11-bit addr, 8-bit data)
//   cpu_reset                   bit 0 of the control register
//
// Parameters:
//   STARVE_LIMIT   losses an eligible instruction read may suffer to data
//                  requests before it is forced to win once (>= 1)
//   UNMAPPED_DATA  value returned for unmapped or write-only reads
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int          STARVE_LIMIT  = 4,
    parameter logic [15:0] UNMAPPED_DATA = 16'hEEEE
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        dbg_we,
    input  logic [15:0] dbg_waddr,
    input  logic [15:0] dbg_wdata,

    input  logic [15:0] ins_rd_addr,
    input  logic        ins_rd_req,
    output logic        ins_rd_rdy,
    output logic [15:0] ins_rd_data,

    input  logic [15:0] dat_rw_addr,
    input  logic [15:0] dat_wr_data,
    input  logic        dat_rd_req,
    input  logic        dat_wr_req,
    output logic        dat_rd_rdy,
    output logic        dat_wr_rdy,
    output logic [15:0] dat_rd_data,

    output logic [15:0] sram_raddr,
    output logic        sram_re,
    input  logic [15:0] sram_rdata,
    output logic [15:0] sram_waddr,
    output logic [15:0] sram_wdata,
    output logic        sram_we,

    output logic [10:0] vram_waddr,
    output logic [7:0]  vram_wdata,
    output logic        vram_we,

    output logic        cpu_reset
);

    // Wide enough to hold the value STARVE_LIMIT itself (saturation point).
    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        REG_SRAM,
        REG_VRAM,
        REG_CTRL,
        REG_NONE
    } region_t;

    typedef enum logic [2:0] {
        G_NONE,
        G_DBG,
        G_DWR,
        G_DRD,
        G_INS
    } grant_t;

    function automatic region_t decode(input logic [15:0] addr);
        case (addr[15:12])
            4'h0:    decode = REG_SRAM;
            4'h8:    decode = REG_VRAM;
            4'hF:    decode = REG_CTRL;
            default: decode = REG_NONE;
        endcase
    endfunction

    grant_t          grant;
    region_t         acc_region;
    logic [15:0]     acc_addr;
    logic [15:0]     acc_wdata;
    logic            acc_write;
    logic            acc_read;
    logic            ctrl_we;

    logic            ins_elig;
    logic            dwr_elig;
    logic            drd_elig;
    logic            starved;
    logic [CW-1:0]   starve_cnt;

    // Registered state of the read that completes this cycle.
    logic            rd_from_sram;
    logic [15:0]     rd_fixed;
    logic [15:0]     rd_result;
    logic [15:0]     ins_hold;
    logic [15:0]     dat_hold;

    // A requester keeps its req high during its own rdy cycle; masking it
    // there stops the same request from being granted twice.
    assign ins_elig = ins_rd_req && !ins_rd_rdy;
    assign dwr_elig = dat_wr_req && !dat_wr_rdy;
    assign drd_elig = dat_rd_req && !dat_rd_rdy;
    assign starved  = (starve_cnt == LIMIT);

    // Grant selection. Debug writes cannot be stalled, so they pre-empt every
    // CPU request. Otherwise writes beat reads and data beats instructions,
    // except when the instruction side has lost often enough to be starved.
    // Nothing is granted while reset is high so all strobes stay quiet.
    always_comb begin
        grant = G_NONE;
        if (!reset) begin
            if (dbg_we) begin
                grant = G_DBG;
            end else if (ins_elig && starved) begin
                grant = G_INS;
            end else if (dwr_elig) begin
                grant = G_DWR;
            end else if (drd_elig) begin
                grant = G_DRD;
            end else if (ins_elig) begin
                grant = G_INS;
            end
        end
    end

    // Route the winner's address/data onto a single access bus.
    always_comb begin
        acc_addr  = 16'h0000;
        acc_wdata = 16'h0000;
        acc_write = 1'b0;
        acc_read  = 1'b0;
        case (grant)
            G_DBG: begin
                acc_addr  = dbg_waddr;
                acc_wdata = dbg_wdata;
                acc_write = 1'b1;
            end
            G_DWR: begin
                acc_addr  = dat_rw_addr;
                acc_wdata = dat_wr_data;
                acc_write = 1'b1;
            end
            G_DRD: begin
                acc_addr  = dat_rw_addr;
                acc_read  = 1'b1;
            end
            G_INS: begin
                acc_addr  = ins_rd_addr;
                acc_read  = 1'b1;
            end
            default: begin
                acc_addr  = 16'h0000;
            end
        endcase
    end

    assign acc_region = decode(acc_addr);

    // Memory-side strobes are combinational in the grant cycle. Address and
    // data buses are zeroed when their strobe is low so idle outputs read 0.
    always_comb begin
        sram_we    = acc_write && (acc_region == REG_SRAM);
        vram_we    = acc_write && (acc_region == REG_VRAM);
        ctrl_we    = acc_write && (acc_region == REG_CTRL);
        sram_re    = acc_read  && (acc_region == REG_SRAM);

        sram_waddr = sram_we ? acc_addr  : 16'h0000;
        sram_wdata = sram_we ? acc_wdata : 16'h0000;
        vram_waddr = vram_we ? acc_addr[10:0]  : 11'h000;
        vram_wdata = vram_we ? acc_wdata[7:0]  : 8'h00;
        sram_raddr = sram_re ? acc_addr  : 16'h0000;
    end

    // Read data in the completion cycle: SRAM data arrives that cycle, while
    // ctrl/unmapped values were captured at grant time. Outside a rdy pulse
    // each port shows the last value it delivered.
    assign rd_result   = rd_from_sram ? sram_rdata : rd_fixed;
    assign ins_rd_data = ins_rd_rdy ? rd_result : ins_hold;
    assign dat_rd_data = dat_rd_rdy ? rd_result : dat_hold;

    // Control register, completion pulses, read bookkeeping and the
    // instruction starvation counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_reset    <= 1'b0;
            ins_rd_rdy   <= 1'b0;
            dat_rd_rdy   <= 1'b0;
            dat_wr_rdy   <= 1'b0;
            rd_from_sram <= 1'b0;
            rd_fixed     <= 16'h0000;
            ins_hold     <= 16'h0000;
            dat_hold     <= 16'h0000;
            starve_cnt   <= '0;
        end else begin
            if (ctrl_we) begin
                cpu_reset <= acc_wdata[0];
            end

            ins_rd_rdy <= (grant == G_INS);
            dat_rd_rdy <= (grant == G_DRD);
            dat_wr_rdy <= (grant == G_DWR);

            if (acc_read) begin
                rd_from_sram <= (acc_region == REG_SRAM);
                rd_fixed     <= (acc_region == REG_CTRL) ? {15'b0, cpu_reset}
                                                         : UNMAPPED_DATA;
            end

            if (ins_rd_rdy) begin
                ins_hold <= rd_result;
            end
            if (dat_rd_rdy) begin
                dat_hold <= rd_result;
            end

            if (!ins_rd_req || (grant == G_INS)) begin
                starve_cnt <= '0;
            end else if (ins_elig && !starved) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Replaces the fixed "never deny" handshake in the top level with a real arbiter and address decoder.
- Arbitrates three requesters onto one memory system:
  - debug-SPI writes,
  - cpu16 data read/write,
  - cpu16 instruction read.
- Drives the sram read and write ports, the VRAM write port and the control register (cpu_reset). Returns read data and rdy pulses to the CPU.

Parameters:
STARVE_LIMIT, 4, consecutive cycles an instruction request may lose to data requests before it is forced to win once (≥1).
UNMAPPED_DATA, 16'hEEEE, value returned for reads of unmapped or write-only regions.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
dbg_we  in  1  debug write strobe (single cycle, cannot be stalled)
dbg_waddr  in  16  debug write address
dbg_wdata  in  16  debug write data
ins_rd_addr  in  16  cpu instruction read address
ins_rd_req  in  1  cpu instruction read request, held until rdy
ins_rd_rdy  out  1  instruction read done, ins_rd_data valid
ins_rd_data  out  16  instruction read data
dat_rw_addr  in  16  cpu data address
dat_wr_data  in  16  cpu write data
dat_rd_req  in  1  cpu data read request, held until rdy
dat_wr_req  in  1  cpu data write request, held until rdy
dat_rd_rdy  out  1  data read done, dat_rd_data valid
dat_wr_rdy  out  1  data write done
dat_rd_data  out  16  data read data
sram_raddr  out  16  sram read address
sram_re  out  1  sram read enable (data returns next cycle)
sram_rdata  in  16  sram read data
sram_waddr  out  16  sram write address
sram_wdata  out  16  sram write data
sram_we  out  1  sram write enable
vram_waddr  out  11  vram write address (waddr[10:0])
vram_wdata  out  8  vram write data (wdata[7:0])
vram_we  out  1  vram write enable
cpu_reset  out  1  control register bit 0

Behaviour:
- Reset values:
  - all rdy outputs, sram_re, sram_we, vram_we, cpu_reset, starvation counter: 0;
  - data outputs: 0;
  - outstanding flags: clear.
- Decode on addr[15:12]:
  - 0x0 = sram (read/write);
  - 0x8 = vram (write-only);
  - 0xF = ctrl (write: cpu_reset <= wdata[0]; read: {15'b0, cpu_reset});
  - other = unmapped (writes dropped, reads return UNMAPPED_DATA).
- One grant per cycle, to one of: debug write, data write, data read, instruction read.
- dbg_we is granted unconditionally in its own cycle:
  - it blocks all CPU grants that cycle;
  - a CPU request stalls and retries.
- CPU priority, when no dbg_we: dat_wr > dat_rd > ins_rd.
  - Exception: when the starvation counter equals STARVE_LIMIT and ins_rd_req is eligible, ins_rd wins.
- Starvation counter:
  - increments, saturating, each cycle ins_rd_req is eligible but not granted;
  - clears on an ins_rd grant or when ins_rd_req is low.
- Eligibility: a requester is ineligible in the cycle its rdy is asserted, because req is still high that cycle. This prevents a double grant.
- Write grant in cycle N:
  - sram_we / vram_we / ctrl update combinationally in cycle N, using the granted address and data;
  - dat_wr_rdy = 1 in cycle N+1 (CPU writes only).
- Read grant in cycle N:
  - sram_raddr is driven and sram_re = 1 in cycle N;
  - source and region are registered;
  - in cycle N+1, the matching rdy = 1 and data = sram_rdata, ctrl value, or UNMAPPED_DATA.
  - Ctrl and unmapped reads also take exactly one cycle.
- Data outputs hold their last value between rdy pulses.
- Simultaneous dat_rd_req and dat_wr_req: the write is served first; the read follows in a later cycle.
- Grants can issue back-to-back; throughput is one access per cycle.
- Reset mid-operation: in-flight rdy pulses are suppressed, the register is cleared and cpu_reset returns to 0.
- Asserting cpu_reset does not reset the arbiter itself; the CPU is expected to drop its requests.

Test Plan:
1. Reset, then dbg_we to 0x0010 with 0x1234, then ins_rd_req addr 0x0010 → ins_rd_rdy one cycle after grant, ins_rd_data = 0x1234; no other rdy pulses.
2. dat_wr_req to 0xF000 with data 0x0001 → cpu_reset = 1 from the next cycle; dat_wr_rdy pulses once; a dat_rd from 0xF000 returns 0x0001.
3. dbg_we to 0x8005 with 0xABCD in the same cycle as dat_wr_req to 0x0003 → vram_we with addr 5 and data 0xCD first; the sram write to 0x0003 lands the next cycle; dat_wr_rdy pulses in the cycle after that.
4. dat_rd_req from 0x1234, and separately from 0x8000 → rdy after 1 cycle with data 0xEEEE in both cases; sram_re is not used for these data results.
5. dat_rd_req and ins_rd_req held continuously, with the data requester re-requesting immediately after each rdy, STARVE_LIMIT = 4 → ins_rd is granted no later than the 5th cycle; the counter then returns to 0.
6. Assert reset during an outstanding sram read → no rdy pulse follows; all outputs are 0; the next request after reset completes normally.
